// File: rtl/smpl_cpu_param_if.sv
// Bus bundle for the accumulator CPU: asynchronous-read instruction memory
// port plus a data memory port with a ready handshake for wait states.
interface smpl_cpu_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   im_abus;
    logic [ADDR_W+2:0]   im_dbus;
    logic [ADDR_W-1:0]   dm_abus;
    logic [DATA_W-1:0]   dm_in_dbus;
    logic [DATA_W-1:0]   dm_out_dbus;
    logic                rd_mem;
    logic                wr_mem;
    logic                dm_ready;

    // CPU side
    modport master (
        output im_abus,
        input  im_dbus,
        output dm_abus,
        input  dm_in_dbus,
        output dm_out_dbus,
        output rd_mem,
        output wr_mem,
        input  dm_ready
    );

    // Memory side
    modport slave (
        input  im_abus,
        output im_dbus,
        input  dm_abus,
        output dm_in_dbus,
        input  dm_out_dbus,
        input  rd_mem,
        input  wr_mem,
        output dm_ready
    );
endinterface

// File: rtl/smpl_cpu_param.sv
// Parametrised Harvard accumulator CPU. Two-phase FETCH/EXEC machine with a
// terminal HALTED state. Memory instructions stall in EXEC until dm_ready;
// branches complete in EXEC unconditionally. Bus outputs are decoded from
// registered state only, so they are glitch-free functions of the flops.
module smpl_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int PC_RST = 0
) (
    input  logic                clk,
    input  logic                reset,
    smpl_cpu_param_if.master    bus,
    output logic [DATA_W-1:0]   acc_out,
    output logic                carry,
    output logic                halted
);

    localparam int IW = ADDR_W + 3;

    localparam logic [2:0] OP_HALT = 3'b000;
    localparam logic [2:0] OP_LDA  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_STA  = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_JN   = 3'b111;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_EXEC   = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    // Architectural and control registers
    state_t              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic [DATA_W-1:0]   acc_r;
    logic [IW-1:0]       ir_r;
    logic                carry_r;

    // Next-state values
    state_t              state_s;
    logic [ADDR_W-1:0]   pc_s;
    logic [DATA_W-1:0]   acc_s;
    logic [IW-1:0]       ir_s;
    logic                carry_s;

    // Decoded outputs
    logic [ADDR_W-1:0]   dm_abus_s;
    logic                rd_mem_s;
    logic                wr_mem_s;
    logic                halted_s;

    // Instruction fields and ALU result
    logic [2:0]          opcode_s;
    logic [ADDR_W-1:0]   operand_s;
    logic [DATA_W:0]     alu_s;

    // Add or subtract one bit wider than the datapath; the top bit is carry
    // for ADD and borrow (subtrahend larger than acc, unsigned) for SUB.
    function automatic logic [DATA_W:0] alu_f(
        input logic              sub_op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] ax;
        logic [DATA_W:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        if (sub_op) begin
            return ax - bx;
        end else begin
            return ax + bx;
        end
    endfunction

    assign opcode_s  = ir_r[IW-1:ADDR_W];
    assign operand_s = ir_r[ADDR_W-1:0];
    assign alu_s     = alu_f(opcode_s == OP_SUB, acc_r, bus.dm_in_dbus);

    // State and architectural register update; reset overrides any stall or HALT
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
            pc_r    <= ADDR_W'(PC_RST);
            acc_r   <= {DATA_W{1'b0}};
            ir_r    <= {IW{1'b0}};
            carry_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            acc_r   <= acc_s;
            ir_r    <= ir_s;
            carry_r <= carry_s;
        end
    end

    // Next-state, datapath and bus-request decode
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        acc_s     = acc_r;
        ir_s      = ir_r;
        carry_s   = carry_r;
        dm_abus_s = {ADDR_W{1'b0}};
        rd_mem_s  = 1'b0;
        wr_mem_s  = 1'b0;
        halted_s  = 1'b0;

        case (state_r)
            ST_FETCH: begin
                ir_s    = bus.im_dbus;
                pc_s    = pc_r + ADDR_W'(1);
                state_s = ST_EXEC;
            end

            ST_EXEC: begin
                case (opcode_s)
                    OP_HALT: begin
                        state_s = ST_HALTED;
                    end
                    OP_LDA: begin
                        dm_abus_s = operand_s;
                        rd_mem_s  = 1'b1;
                        if (bus.dm_ready) begin
                            acc_s   = bus.dm_in_dbus;
                            state_s = ST_FETCH;
                        end else begin
                            state_s = ST_EXEC;
                        end
                    end
                    OP_ADD, OP_SUB: begin
                        dm_abus_s = operand_s;
                        rd_mem_s  = 1'b1;
                        if (bus.dm_ready) begin
                            acc_s   = alu_s[DATA_W-1:0];
                            carry_s = alu_s[DATA_W];
                            state_s = ST_FETCH;
                        end else begin
                            state_s = ST_EXEC;
                        end
                    end
                    OP_STA: begin
                        dm_abus_s = operand_s;
                        wr_mem_s  = 1'b1;
                        if (bus.dm_ready) begin
                            state_s = ST_FETCH;
                        end else begin
                            state_s = ST_EXEC;
                        end
                    end
                    OP_JMP: begin
                        pc_s    = operand_s;
                        state_s = ST_FETCH;
                    end
                    OP_JZ: begin
                        if (acc_r == {DATA_W{1'b0}}) begin
                            pc_s = operand_s;
                        end else begin
                            pc_s = pc_r;
                        end
                        state_s = ST_FETCH;
                    end
                    OP_JN: begin
                        if (acc_r[DATA_W-1]) begin
                            pc_s = operand_s;
                        end else begin
                            pc_s = pc_r;
                        end
                        state_s = ST_FETCH;
                    end
                    default: begin
                        state_s = ST_HALTED;
                    end
                endcase
            end

            ST_HALTED: begin
                halted_s = 1'b1;
                state_s  = ST_HALTED;
            end

            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    assign bus.im_abus     = pc_r;
    assign bus.dm_abus     = dm_abus_s;
    assign bus.dm_out_dbus = acc_r;
    assign bus.rd_mem      = rd_mem_s;
    assign bus.wr_mem      = wr_mem_s;
    assign acc_out         = acc_r;
    assign carry           = carry_r;
    assign halted          = halted_s;

endmodule

// File: tb/tb_smpl_cpu_param.sv
// Self-checking bench for smpl_cpu_param: an 8/5 instance and a 16/8 instance
// with behavioural instruction/data memories owned by the stimulus process.
module tb_smpl_cpu_param;

    logic clk;
    logic reset8;
    logic reset16;
    logic [7:0]  acc8;
    logic        carry8;
    logic        halted8;
    logic [15:0] acc16;
    logic        carry16;
    logic        halted16;

    logic [7:0]  imem8  [32];
    logic [7:0]  dmem8  [32];
    logic [10:0] imem16 [256];
    logic [15:0] dmem16 [256];

    int total;
    int bad;

    smpl_cpu_param_if #(.DATA_W(8),  .ADDR_W(5)) b8 ();
    smpl_cpu_param_if #(.DATA_W(16), .ADDR_W(8)) b16 ();

    smpl_cpu_param #(.DATA_W(8), .ADDR_W(5), .PC_RST(0)) dut8 (
        .clk(clk), .reset(reset8), .bus(b8),
        .acc_out(acc8), .carry(carry8), .halted(halted8)
    );

    smpl_cpu_param #(.DATA_W(16), .ADDR_W(8), .PC_RST(0)) dut16 (
        .clk(clk), .reset(reset16), .bus(b16),
        .acc_out(acc16), .carry(carry16), .halted(halted16)
    );

    assign b8.im_dbus     = imem8[b8.im_abus];
    assign b8.dm_in_dbus  = dmem8[b8.dm_abus];
    assign b16.im_dbus    = imem16[b16.im_abus];
    assign b16.dm_in_dbus = dmem16[b16.dm_abus];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_acc;
        logic       exp_c;
    } vec_t;

    typedef struct {
        logic [7:0] acc;
        logic       c;
    } exp_t;

    exp_t sb_q [$];

    function automatic logic [7:0] ins8(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    function automatic logic [10:0] ins16(input logic [2:0] op, input logic [7:0] a);
        return {op, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: data memory writes land at the edge where wr_mem and dm_ready are both high
    task automatic tick();
        logic        w8;
        logic        w16;
        logic [4:0]  a8;
        logic [7:0]  d8;
        logic [7:0]  a16;
        logic [15:0] d16;
        w8  = b8.wr_mem && b8.dm_ready;
        a8  = b8.dm_abus;
        d8  = b8.dm_out_dbus;
        w16 = b16.wr_mem && b16.dm_ready;
        a16 = b16.dm_abus;
        d16 = b16.dm_out_dbus;
        total++;
        if (b8.rd_mem && b8.wr_mem) begin
            bad++;
            $display("FAIL rd_wr_excl: rd=%0b wr=%0b expected not both", b8.rd_mem, b8.wr_mem);
        end
        @(posedge clk);
        if (w8) dmem8[a8] = d8;
        if (w16) dmem16[a16] = d16;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear8();
        for (int i = 0; i < 32; i++) begin
            imem8[i] = 8'h00;
            dmem8[i] = 8'h00;
        end
    endtask

    task automatic reset_cpu8();
        reset8 = 1'b1;
        b8.dm_ready = 1'b1;
        tick();
        reset8 = 1'b0;
    endtask

    vec_t vecs [8];

    initial begin
        exp_t e;
        bit   done;
        total = 0;
        bad   = 0;
        reset8  = 1'b1;
        reset16 = 1'b1;
        b8.dm_ready  = 1'b1;
        b16.dm_ready = 1'b1;
        clear8();
        for (int i = 0; i < 256; i++) begin
            imem16[i] = 11'h000;
            dmem16[i] = 16'h0000;
        end
        #1;

        vecs[0] = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[1] = '{3'b010, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{3'b010, 8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[3] = '{3'b010, 8'h12, 8'h34, 8'h46, 1'b0};
        vecs[4] = '{3'b011, 8'h05, 8'h03, 8'h02, 1'b0};
        vecs[5] = '{3'b011, 8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[6] = '{3'b011, 8'h80, 8'h80, 8'h00, 1'b0};
        vecs[7] = '{3'b011, 8'h00, 8'hFF, 8'h01, 1'b1};

        // Reset state
        reset_cpu8();
        chk("rst_acc", 32'(acc8), 32'h0);
        chk("rst_carry", 32'(carry8), 32'h0);
        chk("rst_halted", 32'(halted8), 32'h0);
        chk("rst_rd", 32'(b8.rd_mem), 32'h0);
        chk("rst_wr", 32'(b8.wr_mem), 32'h0);
        chk("rst_dm_abus", 32'(b8.dm_abus), 32'h0);
        chk("rst_pc", 32'(b8.im_abus), 32'h0);

        // Arithmetic vectors: LDA 0; op 1; HALT, result scoreboarded at halt
        for (int v = 0; v < 8; v++) begin
            clear8();
            dmem8[0] = vecs[v].a;
            dmem8[1] = vecs[v].b;
            imem8[0] = ins8(3'b001, 5'd0);
            imem8[1] = ins8(vecs[v].op, 5'd1);
            imem8[2] = ins8(3'b000, 5'd0);
            sb_q.push_back('{vecs[v].exp_acc, vecs[v].exp_c});
            reset_cpu8();
            done = 1'b0;
            for (int c = 0; c < 30 && !done; c++) begin
                tick();
                if (halted8) done = 1'b1;
            end
            e = sb_q.pop_front();
            if (!done) begin
                total++;
                bad++;
                $display("FAIL vec%0d_timeout: halted=0 expected 1", v);
            end else begin
                chk($sformatf("vec%0d_acc", v), 32'(acc8), 32'(e.acc));
                chk($sformatf("vec%0d_carry", v), 32'(carry8), 32'(e.c));
            end
        end

        // Scenario 1: LDA 2; ADD 1; STA 3; HALT with no wait states
        clear8();
        dmem8[0] = 8'h01; dmem8[1] = 8'h07; dmem8[2] = 8'h05; dmem8[3] = 8'h00;
        imem8[0] = ins8(3'b001, 5'd2);
        imem8[1] = ins8(3'b010, 5'd1);
        imem8[2] = ins8(3'b100, 5'd3);
        imem8[3] = ins8(3'b000, 5'd0);
        reset_cpu8();
        ticks(7);
        chk("s1_halted_c7", 32'(halted8), 32'h0);
        tick();
        chk("s1_halted_c8", 32'(halted8), 32'h1);
        chk("s1_acc", 32'(acc8), 32'h0C);
        chk("s1_carry", 32'(carry8), 32'h0);
        chk("s1_mem3", 32'(dmem8[3]), 32'h0C);
        chk("s1_pc", 32'(b8.im_abus), 32'h4);
        chk("s1_halt_rd", 32'(b8.rd_mem), 32'h0);
        ticks(2);
        chk("s1_pc_frozen", 32'(b8.im_abus), 32'h4);

        // Scenario 2: same program with three wait states on ADD
        dmem8[3] = 8'h00;
        reset_cpu8();
        ticks(3);
        b8.dm_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("s2_rd_w%0d", k), 32'(b8.rd_mem), 32'h1);
            chk($sformatf("s2_abus_w%0d", k), 32'(b8.dm_abus), 32'h1);
            chk($sformatf("s2_acc_w%0d", k), 32'(acc8), 32'h05);
            tick();
        end
        chk("s2_acc_stall_end", 32'(acc8), 32'h05);
        b8.dm_ready = 1'b1;
        tick();
        chk("s2_acc", 32'(acc8), 32'h0C);
        ticks(3);
        chk("s2_halted_c10", 32'(halted8), 32'h0);
        tick();
        chk("s2_halted_c11", 32'(halted8), 32'h1);
        chk("s2_mem3", 32'(dmem8[3]), 32'h0C);

        // Scenario 3: SUB to zero/negative, taken and untaken JZ/JN
        clear8();
        dmem8[0] = 8'h01;
        imem8[0]  = ins8(3'b001, 5'd0);
        imem8[1]  = ins8(3'b011, 5'd0);
        imem8[2]  = ins8(3'b110, 5'd6);
        imem8[6]  = ins8(3'b011, 5'd0);
        imem8[7]  = ins8(3'b111, 5'd10);
        imem8[10] = ins8(3'b001, 5'd0);
        imem8[11] = ins8(3'b110, 5'd20);
        imem8[12] = ins8(3'b111, 5'd20);
        imem8[13] = ins8(3'b000, 5'd0);
        reset_cpu8();
        ticks(4);
        chk("s3_sub1_acc", 32'(acc8), 32'h00);
        chk("s3_sub1_carry", 32'(carry8), 32'h0);
        ticks(2);
        chk("s3_jz_taken_pc", 32'(b8.im_abus), 32'd6);
        ticks(2);
        chk("s3_sub2_acc", 32'(acc8), 32'hFF);
        chk("s3_sub2_carry", 32'(carry8), 32'h1);
        ticks(2);
        chk("s3_jn_taken_pc", 32'(b8.im_abus), 32'd10);
        ticks(2);
        chk("s3_lda_acc", 32'(acc8), 32'h01);
        chk("s3_lda_keeps_carry", 32'(carry8), 32'h1);
        ticks(2);
        chk("s3_jz_untaken_pc", 32'(b8.im_abus), 32'd12);
        ticks(2);
        chk("s3_jn_untaken_pc", 32'(b8.im_abus), 32'd13);
        ticks(2);
        chk("s3_halted", 32'(halted8), 32'h1);

        // Scenario 4: jump to the last address and wrap the pc
        clear8();
        dmem8[0] = 8'h3C;
        imem8[0]  = ins8(3'b101, 5'd31);
        imem8[31] = ins8(3'b001, 5'd0);
        reset_cpu8();
        ticks(2);
        chk("s4_pc31", 32'(b8.im_abus), 32'd31);
        tick();
        chk("s4_pc_wrap", 32'(b8.im_abus), 32'd0);
        tick();
        chk("s4_lda_acc", 32'(acc8), 32'h3C);
        chk("s4_refetch0", 32'(b8.im_abus), 32'd0);
        ticks(2);
        chk("s4_jmp_again", 32'(b8.im_abus), 32'd31);

        // Scenario 5a: reset during a stalled STA cancels the write
        clear8();
        dmem8[3] = 8'h55;
        imem8[0] = ins8(3'b001, 5'd1);
        imem8[1] = ins8(3'b100, 5'd3);
        dmem8[1] = 8'hA7;
        reset_cpu8();
        ticks(3);
        b8.dm_ready = 1'b0;
        chk("s5_wr_wait", 32'(b8.wr_mem), 32'h1);
        tick();
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0;
        chk("s5_wr_after_rst", 32'(b8.wr_mem), 32'h0);
        chk("s5_pc_after_rst", 32'(b8.im_abus), 32'h0);
        chk("s5_acc_after_rst", 32'(acc8), 32'h0);
        chk("s5_mem_kept", 32'(dmem8[3]), 32'h55);

        // Scenario 5b: reset while halted restarts from address 0
        clear8();
        reset_cpu8();
        ticks(2);
        chk("s5_halted", 32'(halted8), 32'h1);
        reset8 = 1'b1;
        tick();
        reset8 = 1'b0;
        chk("s5_unhalted", 32'(halted8), 32'h0);
        chk("s5_restart_pc", 32'(b8.im_abus), 32'h0);
        tick();
        chk("s5_fetch_pc", 32'(b8.im_abus), 32'h1);

        // Scenario 6: wide configuration, 0 - 1 gives all ones with borrow
        dmem16[0] = 16'h0000;
        dmem16[1] = 16'h0001;
        imem16[0]  = ins16(3'b001, 8'd0);
        imem16[1]  = ins16(3'b011, 8'd1);
        imem16[2]  = ins16(3'b111, 8'd40);
        imem16[40] = ins16(3'b000, 8'd0);
        b16.dm_ready = 1'b1;
        reset16 = 1'b1;
        tick();
        reset16 = 1'b0;
        ticks(4);
        chk("s6_acc", 32'(acc16), 32'hFFFF);
        chk("s6_carry", 32'(carry16), 32'h1);
        ticks(2);
        chk("s6_jn_pc", 32'(b16.im_abus), 32'd40);
        ticks(2);
        chk("s6_halted", 32'(halted16), 32'h1);
        chk("s6_pc_after_halt", 32'(b16.im_abus), 32'd41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smpl_cpu_param.md
Name: smpl_cpu_param

Overview:
Parametrised next-generation accumulator CPU with separate instruction and data memory buses (Harvard).
- Generalises the 8-bit / 32-word core to configurable data and address widths.
- Adds a data-memory ready handshake (wait states), a carry/borrow flag, SUB, and an explicit HALT state with a status output.
- Drops into the existing bench and memory models in place of the fixed core; instruction memory stays asynchronous-read.

Parameters:
DATA_W, 8, accumulator and data-bus width
ADDR_W, 5, instruction/data address width; instruction word width is 3+ADDR_W
PC_RST, 0, program counter value after reset

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  synchronous, active-high reset
im_abus  out  ADDR_W  instruction address, equals pc
im_dbus  in  3+ADDR_W  instruction word: [ADDR_W+2:ADDR_W] opcode, [ADDR_W-1:0] operand address
dm_abus  out  ADDR_W  data address
dm_in_dbus  in  DATA_W  read data from data memory
dm_out_dbus  out  DATA_W  write data to data memory, equals acc
rd_mem  out  1  data read request
wr_mem  out  1  data write request
dm_ready  in  1  data memory completes the current rd/wr at this rising edge
acc_out  out  DATA_W  accumulator (debug/observation)
carry  out  1  carry from ADD, borrow from SUB
halted  out  1  core in HALT state

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - pc=PC_RST, acc=0, ir=0, carry=0, state=FETCH.
  - Combinational outputs settle to rd_mem=0, wr_mem=0, halted=0, dm_abus=0.
  - Reset overrides every state, including a pending memory wait and HALT.
- Opcodes:
  - 000 HALT
  - 001 LDA: acc=M[a]
  - 010 ADD: acc=acc+M[a]
  - 011 SUB: acc=acc-M[a]
  - 100 STA: M[a]=acc
  - 101 JMP: pc=a
  - 110 JZ: jump if acc==0
  - 111 JN: jump if acc[DATA_W-1]==1
- State FETCH (1 cycle):
  - im_abus=pc.
  - At the edge: ir<=im_dbus, pc<=pc+1 modulo 2^ADDR_W (wraps from all-ones to 0), go to EXEC.
- State EXEC, memory ops (LDA/ADD/SUB/STA):
  - dm_abus=ir operand; rd_mem=1 for LDA/ADD/SUB; wr_mem=1 for STA.
  - If dm_ready=0 at the edge: stay in EXEC with outputs held stable and no architectural update.
  - If dm_ready=1 at the edge: update acc/carry, go to FETCH.
  - With dm_ready tied high, every memory instruction takes 2 cycles.
- State EXEC, control ops:
  - JMP/JZ/JN ignore dm_ready and take 2 cycles.
  - A taken branch loads pc<=operand.
  - Conditions use acc as it is at the EXEC edge.
- HALT: go to HALTED; halted=1; pc, acc and carry frozen; no bus requests; exit only by reset.
- Arithmetic:
  - ADD/SUB computed in DATA_W+1 bits.
  - acc = low DATA_W bits.
  - carry = bit DATA_W (for SUB: 1 when M[a] > acc unsigned).
  - LDA leaves carry unchanged; STA, jumps and HALT do not touch acc or carry.
- Mutual exclusion:
  - rd_mem and wr_mem are never high together.
  - Both are 0 in FETCH and HALTED.
- Data memory contract: with wr_mem=1, the write happens at the same edge as dm_ready=1.
- Reset asserted during a STA wait: wr_mem is 0 after that edge and no write is issued.

Test Plan:
1. DM={01,07,05,00}, program LDA 2; ADD 1; STA 3; HALT; dm_ready=1 -> acc=0x0C, carry=0, M[3]=0x0C, halted=1 at cycle 8 after reset release, pc=4.
2. Same program, dm_ready=0 for 3 cycles during ADD -> rd_mem=1 and dm_abus=1 held stable, acc stays 0x05 until ready, then acc=0x0C; halted 3 cycles later than in scenario 1.
3. LDA 0; SUB 0; JZ 6; ... ; at 6: SUB 0; JN 10 -> after the first SUB acc=0x00, carry=0, JZ taken (pc=6); after the second SUB acc=0xFF, carry=1, JN taken (pc=10); untaken JZ/JN with acc=0x01 falls through to pc+1.
4. JMP 31, LDA 0 at address 31 -> im_abus=31, then pc wraps to 0 and the next fetch is from address 0.
5. Reset pulsed while STA is waiting (dm_ready=0) -> wr_mem=0 and pc=0 after the edge, M[a] unchanged; reset while halted -> halted=0 and execution restarts at 0.
6. DATA_W=16, ADDR_W=8: LDA (0x0000), SUB (0x0001) -> acc=0xFFFF, carry=1, JN taken; instruction word is 11 bits wide.
